// File: rtl/inst_trace_buffer.sv
// inst_trace_buffer
// Instruction trace history for the KLP32V1 debug outputs. Every retired
// instruction (a change of PC) is recorded as {pc, inst, writeBack, flags}
// into a circular buffer of 2**ADDR_W entries. While frozen, the user steps
// back and forth through the history and the viewed entry drives o_*.
// Optional build macro: TRACE_STOP_ON_FULL_EN -- keep the first DEPTH
// captures after reset and drop later ones instead of overwriting.
module inst_trace_buffer #(
  parameter int ADDR_W = 4
) (
  input  logic              second_clk,
  input  logic              reset,
  input  logic [31:0]       i_pcOut,
  input  logic [31:0]       i_inst,
  input  logic [31:0]       i_writeBack,
  input  logic [3:0]        i_flags,
  input  logic              i_freeze,
  input  logic              i_step_back,
  input  logic              i_step_fwd,
  output logic [31:0]       o_pc,
  output logic [31:0]       o_inst,
  output logic [31:0]       o_wb,
  output logic [3:0]        o_flags,
  output logic [ADDR_W:0]   o_count,
  output logic [ADDR_W-1:0] o_view_off,
  output logic              o_overflow,
  output logic              o_frozen
);

  localparam int               DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    ST_CAPTURE = 1'b0,
    ST_FROZEN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [31:0]         pc_prev_q;
  logic                primed_q;
  logic [ADDR_W-1:0]   view_off_q, view_off_d;
  logic                overflow_q, overflow_d;
  logic                frozen_q, frozen_d;
  logic [99:0]         view_q, view_d;

  // History storage, intentionally not reset: count_q says what is valid.
  logic [99:0]         trace_mem_q [DEPTH];

  logic                pc_changed_s;
  logic                capture_req_s;
  logic                full_s;
  logic                write_en_s;
  logic                lost_s;
  logic [ADDR_W-1:0]   rd_idx_s;
  logic [99:0]         wr_entry_s;

  // Next-state, capture decision, scroll offset and viewed-entry selection.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    view_off_d    = view_off_q;
    overflow_d    = overflow_q;
    view_d        = 100'd0;
    pc_changed_s  = (i_pcOut != pc_prev_q);
    capture_req_s = (state_q == ST_CAPTURE) && (primed_q || pc_changed_s);
    full_s        = (count_q == DEPTH_C);
    wr_entry_s    = {i_pcOut, i_inst, i_writeBack, i_flags};
    rd_idx_s      = wr_ptr_q - ADDR_W'(1) - view_off_q;

    case (state_q)
      ST_CAPTURE: begin
        if (i_freeze) begin
          state_d = ST_FROZEN;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_FROZEN: begin
        if (!i_freeze) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_FROZEN;
        end
      end
      default: begin
        state_d = ST_CAPTURE;
      end
    endcase

`ifdef TRACE_STOP_ON_FULL_EN
    // A full buffer keeps its oldest contents; the new capture is lost.
    write_en_s = capture_req_s && !full_s;
    lost_s     = capture_req_s && full_s;
`else
    // A full buffer overwrites its oldest entry, which is then lost.
    write_en_s = capture_req_s;
    lost_s     = capture_req_s && full_s;
`endif

    if (write_en_s) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (write_en_s && !full_s) begin
      count_d = count_q + (ADDR_W + 1)'(1);
    end else begin
      count_d = count_q;
    end

    // A PC change seen while frozen is an instruction that never gets recorded.
    if (lost_s || ((state_q == ST_FROZEN) && pc_changed_s)) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    if ((state_q == ST_CAPTURE) || !i_freeze) begin
      view_off_d = '0;
    end else if (i_step_back && !i_step_fwd) begin
      if ((count_q != (ADDR_W + 1)'(0)) &&
          ({1'b0, view_off_q} < (count_q - (ADDR_W + 1)'(1)))) begin
        view_off_d = view_off_q + ADDR_W'(1);
      end else begin
        view_off_d = view_off_q;
      end
    end else if (i_step_fwd && !i_step_back) begin
      if (view_off_q != ADDR_W'(0)) begin
        view_off_d = view_off_q - ADDR_W'(1);
      end else begin
        view_off_d = view_off_q;
      end
    end else begin
      view_off_d = view_off_q;
    end

    if (count_q == (ADDR_W + 1)'(0)) begin
      view_d = 100'd0;
    end else begin
      view_d = trace_mem_q[rd_idx_s];
    end

    frozen_d = (state_d == ST_FROZEN);
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge second_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CAPTURE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      pc_prev_q  <= 32'd0;
      primed_q   <= 1'b1;
      view_off_q <= '0;
      overflow_q <= 1'b0;
      frozen_q   <= 1'b0;
      view_q     <= 100'd0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pc_prev_q  <= i_pcOut;
      primed_q   <= 1'b0;
      view_off_q <= view_off_d;
      overflow_q <= overflow_d;
      frozen_q   <= frozen_d;
      view_q     <= view_d;
    end
  end

  // History write port.
  always_ff @(posedge second_clk) begin
    if (write_en_s) begin
      trace_mem_q[wr_ptr_q] <= wr_entry_s;
    end
  end

  assign o_pc       = view_q[99:68];
  assign o_inst     = view_q[67:36];
  assign o_wb       = view_q[35:4];
  assign o_flags    = view_q[3:0];
  assign o_count    = count_q;
  assign o_view_off = view_off_q;
  assign o_overflow = overflow_q;
  assign o_frozen   = frozen_q;

endmodule

// File: tb/tb_inst_trace_buffer.sv
// Directed bench for inst_trace_buffer (ADDR_W = 4, DEPTH = 16).
// Expected values are hand-derived from the intended behaviour; payload
// fields (inst, wb, flags) are derived from the PC by fixed bench functions.
module tb_inst_trace_buffer;

  logic        second_clk;
  logic        reset;
  logic [31:0] i_pcOut;
  logic [31:0] i_inst;
  logic [31:0] i_writeBack;
  logic [3:0]  i_flags;
  logic        i_freeze;
  logic        i_step_back;
  logic        i_step_fwd;
  logic [31:0] o_pc;
  logic [31:0] o_inst;
  logic [31:0] o_wb;
  logic [3:0]  o_flags;
  logic [4:0]  o_count;
  logic [3:0]  o_view_off;
  logic        o_overflow;
  logic        o_frozen;

  int n_tests = 0;
  int n_fail  = 0;

  inst_trace_buffer #(.ADDR_W(4)) dut (
    .second_clk (second_clk),
    .reset      (reset),
    .i_pcOut    (i_pcOut),
    .i_inst     (i_inst),
    .i_writeBack(i_writeBack),
    .i_flags    (i_flags),
    .i_freeze   (i_freeze),
    .i_step_back(i_step_back),
    .i_step_fwd (i_step_fwd),
    .o_pc       (o_pc),
    .o_inst     (o_inst),
    .o_wb       (o_wb),
    .o_flags    (o_flags),
    .o_count    (o_count),
    .o_view_off (o_view_off),
    .o_overflow (o_overflow),
    .o_frozen   (o_frozen)
  );

  initial second_clk = 1'b0;
  always #5 second_clk = ~second_clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h00A0_0013;
  endfunction

  function automatic logic [31:0] wb_of(input logic [31:0] pc);
    return pc + 32'h1000_0000;
  endfunction

  function automatic logic [3:0] flags_of(input logic [31:0] pc);
    return pc[5:2];
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic        fr;
    logic        bk;
    logic        fw;
    logic [4:0]  cnt;
    logic [3:0]  off;
    logic [31:0] epc;
    logic        vis;
    logic        ovf;
    logic        frz;
  } vec_t;

  vec_t vecs [29];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic fr, input logic bk, input logic fw);
    i_pcOut     = pc;
    i_inst      = inst_of(pc);
    i_writeBack = wb_of(pc);
    i_flags     = flags_of(pc);
    i_freeze    = fr;
    i_step_back = bk;
    i_step_fwd  = fw;
  endtask

  task automatic tick();
    @(posedge second_clk);
    #1;
  endtask

  // Check the viewed payload against the entry whose PC is epc.
  task automatic chk_view(input string tag, input logic [31:0] epc, input logic vis);
    chk({tag, "_pc"},    o_pc,           vis ? epc : 32'd0);
    chk({tag, "_inst"},  o_inst,         vis ? inst_of(epc) : 32'd0);
    chk({tag, "_wb"},    o_wb,           vis ? wb_of(epc) : 32'd0);
    chk({tag, "_flags"}, {28'd0, o_flags}, vis ? {28'd0, flags_of(epc)} : 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge second_clk);
    @(negedge second_clk);
    reset = 1'b0;
  endtask

  initial begin
    //                pc      fr    bk    fw    cnt   off   epc     vis   ovf   frz
    vecs[0]  = '{32'd0,  1'b0, 1'b0, 1'b0, 5'd1, 4'd0, 32'd0,  1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'd0,  1'b0, 1'b0, 1'b0, 5'd1, 4'd0, 32'd0,  1'b1, 1'b0, 1'b0};
    vecs[2]  = '{32'd0,  1'b0, 1'b0, 1'b0, 5'd1, 4'd0, 32'd0,  1'b1, 1'b0, 1'b0};
    vecs[3]  = '{32'd4,  1'b0, 1'b0, 1'b0, 5'd2, 4'd0, 32'd0,  1'b1, 1'b0, 1'b0};
    vecs[4]  = '{32'd8,  1'b0, 1'b0, 1'b0, 5'd3, 4'd0, 32'd4,  1'b1, 1'b0, 1'b0};
    vecs[5]  = '{32'd8,  1'b1, 1'b0, 1'b0, 5'd3, 4'd0, 32'd8,  1'b1, 1'b0, 1'b1};
    vecs[6]  = '{32'd8,  1'b1, 1'b1, 1'b0, 5'd3, 4'd1, 32'd8,  1'b1, 1'b0, 1'b1};
    vecs[7]  = '{32'd8,  1'b1, 1'b1, 1'b0, 5'd3, 4'd2, 32'd4,  1'b1, 1'b0, 1'b1};
    vecs[8]  = '{32'd8,  1'b1, 1'b1, 1'b0, 5'd3, 4'd2, 32'd0,  1'b1, 1'b0, 1'b1};
    vecs[9]  = '{32'd8,  1'b1, 1'b1, 1'b0, 5'd3, 4'd2, 32'd0,  1'b1, 1'b0, 1'b1};
    vecs[10] = '{32'd8,  1'b1, 1'b1, 1'b0, 5'd3, 4'd2, 32'd0,  1'b1, 1'b0, 1'b1};
    vecs[11] = '{32'd8,  1'b1, 1'b0, 1'b1, 5'd3, 4'd1, 32'd0,  1'b1, 1'b0, 1'b1};
    vecs[12] = '{32'd8,  1'b1, 1'b0, 1'b1, 5'd3, 4'd0, 32'd4,  1'b1, 1'b0, 1'b1};
    vecs[13] = '{32'd8,  1'b1, 1'b0, 1'b1, 5'd3, 4'd0, 32'd8,  1'b1, 1'b0, 1'b1};
    vecs[14] = '{32'd8,  1'b1, 1'b1, 1'b0, 5'd3, 4'd1, 32'd8,  1'b1, 1'b0, 1'b1};
    vecs[15] = '{32'd8,  1'b1, 1'b1, 1'b1, 5'd3, 4'd1, 32'd4,  1'b1, 1'b0, 1'b1};
    vecs[16] = '{32'd8,  1'b1, 1'b0, 1'b0, 5'd3, 4'd1, 32'd4,  1'b1, 1'b0, 1'b1};
    vecs[17] = '{32'd12, 1'b1, 1'b0, 1'b0, 5'd3, 4'd1, 32'd4,  1'b1, 1'b1, 1'b1};
    vecs[18] = '{32'd12, 1'b0, 1'b0, 1'b0, 5'd3, 4'd0, 32'd4,  1'b1, 1'b1, 1'b0};
    vecs[19] = '{32'd12, 1'b0, 1'b0, 1'b0, 5'd3, 4'd0, 32'd8,  1'b1, 1'b1, 1'b0};
    vecs[20] = '{32'd16, 1'b0, 1'b0, 1'b0, 5'd4, 4'd0, 32'd8,  1'b1, 1'b1, 1'b0};
    vecs[21] = '{32'd16, 1'b0, 1'b0, 1'b0, 5'd4, 4'd0, 32'd16, 1'b1, 1'b1, 1'b0};
    vecs[22] = '{32'd16, 1'b1, 1'b0, 1'b0, 5'd4, 4'd0, 32'd16, 1'b1, 1'b1, 1'b1};
    vecs[23] = '{32'd16, 1'b1, 1'b1, 1'b0, 5'd4, 4'd1, 32'd16, 1'b1, 1'b1, 1'b1};
    vecs[24] = '{32'd16, 1'b1, 1'b1, 1'b0, 5'd4, 4'd2, 32'd8,  1'b1, 1'b1, 1'b1};
    vecs[25] = '{32'd16, 1'b1, 1'b1, 1'b0, 5'd4, 4'd3, 32'd4,  1'b1, 1'b1, 1'b1};
    vecs[26] = '{32'd16, 1'b1, 1'b1, 1'b0, 5'd4, 4'd3, 32'd0,  1'b1, 1'b1, 1'b1};
    vecs[27] = '{32'd16, 1'b0, 1'b0, 1'b0, 5'd4, 4'd0, 32'd0,  1'b1, 1'b1, 1'b0};
    vecs[28] = '{32'd16, 1'b0, 1'b1, 1'b0, 5'd4, 4'd0, 32'd16, 1'b1, 1'b1, 1'b0};

    // Reset state, checked before any clock edge.
    do_reset();
    chk("rst_count", {27'd0, o_count}, 32'd0);
    chk("rst_off",   {28'd0, o_view_off}, 32'd0);
    chk("rst_ovf",   {31'd0, o_overflow}, 32'd0);
    chk("rst_frz",   {31'd0, o_frozen}, 32'd0);
    chk_view("rst", 32'd0, 1'b0);

    // Capture, freeze, scroll, simultaneous steps, lost PC while frozen, resume.
    for (int i = 0; i < 29; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      drive(vecs[i].pc, vecs[i].fr, vecs[i].bk, vecs[i].fw);
      tick();
      chk({tag, "_count"}, {27'd0, o_count}, {27'd0, vecs[i].cnt});
      chk({tag, "_off"},   {28'd0, o_view_off}, {28'd0, vecs[i].off});
      chk({tag, "_ovf"},   {31'd0, o_overflow}, {31'd0, vecs[i].ovf});
      chk({tag, "_frz"},   {31'd0, o_frozen}, {31'd0, vecs[i].frz});
      chk_view(tag, vecs[i].epc, vecs[i].vis);
    end

    // Twenty instructions into a sixteen-entry history.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(32'(4 * i), 1'b0, 1'b0, 1'b0);
      tick();
      if (i == 15) begin
        chk("fill16_count", {27'd0, o_count}, 32'd16);
        chk("fill16_ovf",   {31'd0, o_overflow}, 32'd0);
      end
      if (i == 16) begin
        chk("fill17_ovf", {31'd0, o_overflow}, 32'd1);
      end
    end
    drive(32'd76, 1'b1, 1'b0, 1'b0);
    tick();
    chk("full_count", {27'd0, o_count}, 32'd16);
    chk("full_ovf",   {31'd0, o_overflow}, 32'd1);
`ifdef TRACE_STOP_ON_FULL_EN
    chk_view("full_newest", 32'd60, 1'b1);
`else
    chk_view("full_newest", 32'd76, 1'b1);
`endif
    for (int i = 0; i < 15; i++) begin
      drive(32'd76, 1'b1, 1'b1, 1'b0);
      tick();
    end
    chk("full_off15", {28'd0, o_view_off}, 32'd15);
    drive(32'd76, 1'b1, 1'b1, 1'b0);
    tick();
    chk("full_off_sat", {28'd0, o_view_off}, 32'd15);
`ifdef TRACE_STOP_ON_FULL_EN
    chk_view("full_oldest", 32'd0, 1'b1);
`else
    chk_view("full_oldest", 32'd16, 1'b1);
`endif

    // Reset in the middle of scrolling takes effect without a clock edge.
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_count", {27'd0, o_count}, 32'd0);
    chk("midrst_off",   {28'd0, o_view_off}, 32'd0);
    chk("midrst_ovf",   {31'd0, o_overflow}, 32'd0);
    chk("midrst_frz",   {31'd0, o_frozen}, 32'd0);
    chk_view("midrst", 32'd0, 1'b0);
    drive(32'd76, 1'b0, 1'b0, 1'b0);
    @(negedge second_clk);
    reset = 1'b0;
    tick();
    chk("post_rst_count", {27'd0, o_count}, 32'd1);
    tick();
    chk("post_rst_count2", {27'd0, o_count}, 32'd1);
    chk_view("post_rst", 32'd76, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
